alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 4-bit combinational ALU: accepts one command at a time,
// drives the ALU for one cycle, registers the response and maintains an accumulator.
module alu_issue_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter logic [3:0]  ACC_INIT = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_use_acc,
    input  logic             cmd_clr_acc,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic [3:0]       acc,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned OP_W = 3;
    localparam int unsigned DW   = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]      state_q,   state_d;
    logic            ready_q,   ready_d;
    logic            valid_q,   valid_d;
    logic [OP_W-1:0] op_q,      op_d;
    logic [DW-1:0]   a_q,       a_d;
    logic [DW-1:0]   b_q,       b_d;
    logic [DW-1:0]   res_q,     res_d;
    logic            ovf_q,     ovf_d;
    logic            zero_q,    zero_d;
    logic [DW-1:0]   acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic            accept_c;
    logic [DW-1:0]   eff_a_c;

    assign accept_c = cmd_valid && ready_q;

    // Clear takes priority so a cleared accumulator feeds this very command.
    always_comb begin
        eff_a_c = cmd_a;
        if (cmd_use_acc) begin
            eff_a_c = cmd_clr_acc ? ACC_INIT : acc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_EXEC;
                    op_d    = cmd_op;
                    a_d     = eff_a_c;
                    b_d     = cmd_b;
                    if (cmd_clr_acc) begin
                        acc_d = ACC_INIT;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                op_d    = '0;
                a_d     = '0;
                b_d     = '0;
                res_d   = alu_result;
                ovf_d   = alu_overflow;
                zero_d  = alu_zero;
                if (!alu_overflow) begin
                    acc_d = alu_result;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                op_d    = '0;
                a_d     = '0;
                b_d     = '0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= ACC_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign rsp_valid    = valid_q;
    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign acc          = acc_q;
    assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU sits downstream, a reference
// model predicts each response at accept time, and a monitor checks at the rsp handshake.
module tb_alu_issue_ctrl;

    localparam int unsigned CNT_W    = 2;
    localparam logic [3:0]  ACC_INIT = 4'b0010;

    typedef struct packed {
        logic [3:0]       res;
        logic             ovf;
        logic             zero;
        logic [3:0]       acc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [3:0]       cmd_a = '0;
    logic [3:0]       cmd_b = '0;
    logic             cmd_use_acc = 1'b0;
    logic             cmd_clr_acc = 1'b0;
    logic [2:0]       alu_op;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_result;
    logic             alu_overflow;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [3:0]       rsp_result;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic [3:0]       acc;
    logic [CNT_W-1:0] ovf_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_hs_edge = -1;
    int rdy_mode = 0;   // 0 random, 1 held low, 2 held high

    exp_t exp_q[$];
    logic [3:0] m_acc = ACC_INIT;
    int         m_cnt = 0;

    alu_issue_ctrl #(.CNT_W(CNT_W), .ACC_INIT(ACC_INIT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_clr_acc(cmd_clr_acc),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .acc(acc), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU returning {result, overflow, zero}.
    function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, s;
        logic [3:0] r;
        logic o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        o = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; o = (s > 7) || (s < -8); r = 4'(s); end
            3'd1: begin s = sa - sb; o = (s > 7) || (s < -8); r = 4'(s); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
            default: r = a ^ 4'b1010;
        endcase
        if (o) r = 4'd0;
        return {r, o, (r == 4'd0)};
    endfunction

    assign {alu_result, alu_overflow, alu_zero} = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // rsp_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: rsp_ready = 1'b0;
                2: rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard at each rsp handshake and checks hold-while-stalled.
    logic       stalled = 1'b0;
    logic [5:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else if (rsp_valid) begin
            chk("cmd_ready_low_in_resp", int'(cmd_ready), 0);
            if (stalled) chk("rsp_stable", int'({rsp_result, rsp_overflow, rsp_zero}), int'(held));
            if (rsp_ready) begin
                stalled = 1'b0;
                last_hs_edge = cyc + 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_result", int'(rsp_result), int'(e.res));
                    chk("rsp_overflow", int'(rsp_overflow), int'(e.ovf));
                    chk("rsp_zero", int'(rsp_zero), int'(e.zero));
                    chk("acc", int'(acc), int'(e.acc));
                    chk("ovf_count", int'(ovf_count), int'(e.cnt));
                end
            end else begin
                stalled = 1'b1;
                held = {rsp_result, rsp_overflow, rsp_zero};
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Issue one command; the model predicts its response at accept time.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic use_acc, input logic clr, input bit check_pipe,
                        output int acc_edge);
        logic [3:0] eff;
        logic [5:0] r;
        exp_t e;
        int n;
        n = 0;
        acc_edge = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            return;
        end
        chk("alu_idle_zero", int'({alu_op, alu_a, alu_b}), 0);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_clr_acc = clr;
        cmd_valid = 1'b1;
        acc_edge = cyc + 1;
        eff = use_acc ? (clr ? ACC_INIT : m_acc) : a;
        if (clr) m_acc = ACC_INIT;
        r = alu_f(op, eff, b);
        if (!r[1]) m_acc = r[5:2];
        else if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        e.res = r[5:2]; e.ovf = r[1]; e.zero = r[0]; e.acc = m_acc; e.cnt = CNT_W'(m_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        cmd_use_acc = 1'($urandom); cmd_clr_acc = 1'($urandom);
        if (check_pipe) begin
            @(negedge clk);
            chk("exec_alu_op", int'(alu_op), int'(op));
            chk("exec_alu_a", int'(alu_a), int'(eff));
            chk("exec_alu_b", int'(alu_b), int'(b));
            chk("exec_rsp_valid", int'(rsp_valid), 0);
            @(negedge clk);
            chk("latency_rsp_valid", int'(rsp_valid), 1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_regs"}, int'({rsp_result, rsp_overflow, rsp_zero}), 0);
        chk({tag, "_alu"}, int'({alu_op, alu_a, alu_b}), 0);
        chk({tag, "_acc"}, int'(acc), int'(ACC_INIT));
        chk({tag, "_ovf_count"}, int'(ovf_count), 0);
    endtask

    initial begin
        int ae;
        int n;
        #23;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, then saturation of the 2-bit overflow counter
        rdy_mode = 2;
        send(3'd0, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, ae);
        send(3'd0, 4'd7, 4'd1, 1'b0, 1'b0, 1'b1, ae);
        send(3'd0, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, ae);
        send(3'd1, 4'd9, 4'd1, 1'b1, 1'b0, 1'b1, ae);
        send(3'd0, 4'd9, 4'd6, 1'b1, 1'b1, 1'b1, ae);
        send(3'd6, 4'b1111, 4'b0010, 1'b0, 1'b0, 1'b1, ae);
        send(3'd6, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b1, ae);
        send(3'd7, 4'd5, 4'd3, 1'b0, 1'b0, 1'b1, ae);
        send(3'd2, 4'd5, 4'd0, 1'b0, 1'b1, 1'b1, ae);
        for (int i = 0; i < 5; i++) send(3'd1, 4'b1000, 4'd1, 1'b0, 1'b0, 1'b1, ae);

        // Randomized traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            send(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1, ae);
        end

        // Backpressure: hold rsp_ready low, present a competing command meanwhile
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        send(3'd5, 4'd6, 4'd3, 1'b0, 1'b0, 1'b1, ae);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", int'(cmd_ready), 0);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
        end
        rdy_mode = 2;
        send(3'd4, 4'd8, 4'd1, 1'b0, 1'b0, 1'b1, ae);
        chk("accept_after_hs", ae, last_hs_edge + 1);

        // Reset during EXEC discards the command
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        send(3'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, ae);
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_acc = ACC_INIT;
        m_cnt = 0;
        check_reset_state("midexec_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", int'(rsp_valid), 0);
        end
        send(3'd0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b1, ae);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
